game_collision_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 25 ++
 rtl/frame_event_latch.sv | 27 ++
 rtl/game_collision_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_collision_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the Digger collision/event controller.
// Gold-bag state encodings, player life-cycle states and counter widths.
package game_pkg;

    localparam int LIVES_W      = 4;
    localparam int GOLD_STATE_W = 4;
    localparam int DYING_W      = 8;

    localparam logic [GOLD_STATE_W-1:0] GOLD_IDLE    = 4'd0;
    localparam logic [GOLD_STATE_W-1:0] GOLD_FALLING = 4'd1;
    localparam logic [GOLD_STATE_W-1:0] GOLD_OPEN    = 4'd2;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        GAME_OVER = 2'd2
    } player_state_t;

    function automatic logic [LIVES_W-1:0] lives_dec(
        input logic [LIVES_W-1:0] l
    );
        return (l == '0) ? '0 : l - 1'b1;
    endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Sticky per-frame accumulator; on startOfFrame the frame's flags become
// a one-cycle pulse and the accumulator restarts with the current cycle.
module frame_event_latch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sof,
    input  logic [W-1:0] cond,
    output logic [W-1:0] flags,
    output logic [W-1:0] pulse
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
            pulse <= '0;
        end else if (sof) begin
            pulse <= flags;
            flags <= cond;
        end else begin
            pulse <= '0;
            flags <= flags | cond;
        end
    end

endmodule

// File: rtl/game_collision_ctrl.sv
// Frame-based collision/event controller for the Digger playfield.
// Accumulates per-pixel overlaps per frame and runs the player life cycle.
module game_collision_ctrl
    import game_pkg::*;
#(
    parameter int N_GOLD       = 4,
    parameter int N_ALIEN      = 3,
    parameter int INIT_LIVES   = 3,
    parameter int DEATH_FRAMES = 60
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic                       drawing_request_terrain,
    input  logic                       drawing_request_player,
    input  logic                       shot_dr,
    input  logic [N_ALIEN-1:0]         alien_dr,
    input  logic [N_GOLD-1:0]          gold_dr,
    input  logic [N_GOLD*GOLD_STATE_W-1:0] gold_state,
    input  logic                       player_awake,
    output logic                       collision_player_terrain,
    output logic                       colision_fire,
    output logic [N_GOLD-1:0]          collision_gold,
    output logic [N_GOLD-1:0]          player_eat_gold,
    output logic [N_ALIEN-1:0]         alien_died,
    output logic                       player_died,
    output logic                       player_respawn,
    output logic                       game_over,
    output logic [LIVES_W-1:0]         lives,
    output logic                       player_alive
);

    logic                any_alien;
    logic [N_GOLD-1:0]   gold_falling;
    logic [N_GOLD-1:0]   gold_open;
    logic                fire_cond;
    logic [N_GOLD-1:0]   gold_cond;
    logic [N_GOLD-1:0]   eat_cond;
    logic [N_ALIEN-1:0]  adie_cond;
    logic                pdie_cond;

    logic                fire_flags, fire_pulse;
    logic [N_GOLD-1:0]   gold_flags, gold_pulse;
    logic [N_GOLD-1:0]   eat_flags, eat_pulse;
    logic [N_ALIEN-1:0]  adie_flags, adie_pulse;
    logic                pdie_flags, pdie_pulse;

    player_state_t       state;
    logic [DYING_W-1:0]  dying_cnt;
    logic                unused_sigs;

    always_comb begin
        any_alien    = |alien_dr;
        gold_falling = '0;
        gold_open    = '0;
        for (int i = 0; i < N_GOLD; i++) begin
            gold_falling[i] = gold_dr[i] &&
                (gold_state[i*GOLD_STATE_W +: GOLD_STATE_W] == GOLD_FALLING);
            gold_open[i] = gold_dr[i] &&
                (gold_state[i*GOLD_STATE_W +: GOLD_STATE_W] == GOLD_OPEN);
        end
        fire_cond = shot_dr & (drawing_request_terrain | any_alien);
        gold_cond = gold_dr & {N_GOLD{drawing_request_player | any_alien}};
        eat_cond  = gold_open & {N_GOLD{drawing_request_player}};
        adie_cond = alien_dr & {N_ALIEN{shot_dr | (|gold_falling)}};
        pdie_cond = drawing_request_player & player_awake &
                    (any_alien | (|gold_falling));
    end

    assign collision_player_terrain =
        drawing_request_terrain & drawing_request_player;

    frame_event_latch #(.W(1)) u_fire (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .cond  (fire_cond),
        .flags (fire_flags),
        .pulse (fire_pulse)
    );

    frame_event_latch #(.W(N_GOLD)) u_gold (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .cond  (gold_cond),
        .flags (gold_flags),
        .pulse (gold_pulse)
    );

    frame_event_latch #(.W(N_GOLD)) u_eat (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .cond  (eat_cond),
        .flags (eat_flags),
        .pulse (eat_pulse)
    );

    frame_event_latch #(.W(N_ALIEN)) u_adie (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .cond  (adie_cond),
        .flags (adie_flags),
        .pulse (adie_pulse)
    );

    // The FSM reacts to the accumulated flag at the same edge the pulses load.
    frame_event_latch #(.W(1)) u_pdie (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .cond  (pdie_cond),
        .flags (pdie_flags),
        .pulse (pdie_pulse)
    );

    assign unused_sigs = ^{fire_flags, gold_flags, eat_flags,
                           adie_flags, pdie_pulse};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ALIVE;
            lives          <= LIVES_W'(INIT_LIVES);
            dying_cnt      <= '0;
            player_died    <= 1'b0;
            player_respawn <= 1'b0;
        end else begin
            player_died    <= 1'b0;
            player_respawn <= 1'b0;
            if (startOfFrame) begin
                unique case (state)
                    ALIVE: begin
                        if (pdie_flags) begin
                            player_died <= 1'b1;
                            lives       <= lives_dec(lives);
                            dying_cnt   <= DYING_W'(DEATH_FRAMES);
                            state       <= DYING;
                        end
                    end
                    DYING: begin
                        dying_cnt <= dying_cnt - 1'b1;
                        if (dying_cnt <= DYING_W'(1)) begin
                            dying_cnt <= '0;
                            if (lives == '0) begin
                                state <= GAME_OVER;
                            end else begin
                                player_respawn <= 1'b1;
                                state          <= ALIVE;
                            end
                        end
                    end
                    GAME_OVER: begin
                    end
                    default: state <= GAME_OVER;
                endcase
            end
        end
    end

    assign player_alive = (state == ALIVE);
    assign game_over    = (state == GAME_OVER);

    // Game over silences every frame report, including the entry cycle.
    assign colision_fire   = fire_pulse & ~game_over;
    assign collision_gold  = gold_pulse & {N_GOLD{~game_over}};
    assign player_eat_gold = eat_pulse & {N_GOLD{~game_over}};
    assign alien_died      = adie_pulse & {N_ALIEN{~game_over}};

endmodule

// File: tb/tb_game_collision_ctrl.sv
// Self-checking bench for game_collision_ctrl: a frame-level model compared
// every cycle against two instances, plus directed literal expectations.
module tb_game_collision_ctrl;

    localparam int NG = 4;
    localparam int NA = 3;

    logic clk = 1'b0;
    logic reset, sof, terr, plr, shot, awake;
    logic [NA-1:0]   adr;
    logic [NG-1:0]   gdr;
    logic [NG*4-1:0] gst;

    always #5 clk = ~clk;

    logic          d0_cpt, d0_fire, d0_died, d0_resp, d0_go, d0_alive;
    logic [NG-1:0] d0_gold, d0_eat;
    logic [NA-1:0] d0_adie;
    logic [3:0]    d0_lives;
    logic          d1_cpt, d1_fire, d1_died, d1_resp, d1_go, d1_alive;
    logic [NG-1:0] d1_gold, d1_eat;
    logic [NA-1:0] d1_adie;
    logic [3:0]    d1_lives;

    game_collision_ctrl #(
        .N_GOLD(NG), .N_ALIEN(NA), .INIT_LIVES(3), .DEATH_FRAMES(60)
    ) dut0 (
        .clk                      (clk),
        .reset                    (reset),
        .startOfFrame             (sof),
        .drawing_request_terrain  (terr),
        .drawing_request_player   (plr),
        .shot_dr                  (shot),
        .alien_dr                 (adr),
        .gold_dr                  (gdr),
        .gold_state               (gst),
        .player_awake             (awake),
        .collision_player_terrain (d0_cpt),
        .colision_fire            (d0_fire),
        .collision_gold           (d0_gold),
        .player_eat_gold          (d0_eat),
        .alien_died               (d0_adie),
        .player_died              (d0_died),
        .player_respawn           (d0_resp),
        .game_over                (d0_go),
        .lives                    (d0_lives),
        .player_alive             (d0_alive)
    );

    game_collision_ctrl #(
        .N_GOLD(NG), .N_ALIEN(NA), .INIT_LIVES(1), .DEATH_FRAMES(4)
    ) dut1 (
        .clk                      (clk),
        .reset                    (reset),
        .startOfFrame             (sof),
        .drawing_request_terrain  (terr),
        .drawing_request_player   (plr),
        .shot_dr                  (shot),
        .alien_dr                 (adr),
        .gold_dr                  (gdr),
        .gold_state               (gst),
        .player_awake             (awake),
        .collision_player_terrain (d1_cpt),
        .colision_fire            (d1_fire),
        .collision_gold           (d1_gold),
        .player_eat_gold          (d1_eat),
        .alien_died               (d1_adie),
        .player_died              (d1_died),
        .player_respawn           (d1_resp),
        .game_over                (d1_go),
        .lives                    (d1_lives),
        .player_alive             (d1_alive)
    );

    logic [20:0] got [2];
    assign got[0] = {d0_fire, d0_gold, d0_eat, d0_adie, d0_died, d0_resp,
                     d0_go, d0_lives, d0_alive, d0_cpt};
    assign got[1] = {d1_fire, d1_gold, d1_eat, d1_adie, d1_died, d1_resp,
                     d1_go, d1_lives, d1_alive, d1_cpt};

    int total = 0;
    int bad   = 0;

    function automatic int init_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int df_of(input int k);
        return (k == 0) ? 60 : 4;
    endfunction

    // What this cycle's pixels mean, straight from the overlap rules
    logic          c_fire, c_pdie, c_any_alien, c_fall;
    logic [NG-1:0] c_gold, c_eat;
    logic [NA-1:0] c_adie;

    always_comb begin
        c_any_alien = |adr;
        c_fall      = 1'b0;
        c_gold      = '0;
        c_eat       = '0;
        for (int i = 0; i < NG; i++) begin
            if (gdr[i] && gst[i*4 +: 4] == 4'd1) c_fall = 1'b1;
            c_gold[i] = gdr[i] & (plr | c_any_alien);
            c_eat[i]  = gdr[i] & plr & (gst[i*4 +: 4] == 4'd2);
        end
        c_fire = shot & (terr | c_any_alien);
        c_adie = (shot | c_fall) ? adr : '0;
        c_pdie = plr & awake & (c_any_alien | c_fall);
    end

    // Frame-level model: accumulated frame contents and life bookkeeping
    logic          a_fire, a_pdie, e_fire;
    logic [NG-1:0] a_gold, a_eat, e_gold, e_eat;
    logic [NA-1:0] a_adie, e_adie;
    int            m_lives [2];
    int            m_mode  [2];
    int            m_left  [2];
    logic          e_died  [2];
    logic          e_resp  [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_fire <= 1'b0; a_pdie <= 1'b0; a_gold <= '0;
            a_eat  <= '0;   a_adie <= '0;
            e_fire <= 1'b0; e_gold <= '0; e_eat <= '0; e_adie <= '0;
            for (int k = 0; k < 2; k++) begin
                m_lives[k] <= init_of(k);
                m_mode[k]  <= 0;
                m_left[k]  <= 0;
                e_died[k]  <= 1'b0;
                e_resp[k]  <= 1'b0;
            end
        end else if (sof) begin
            e_fire <= a_fire; e_gold <= a_gold; e_eat <= a_eat;
            e_adie <= a_adie;
            a_fire <= c_fire; a_gold <= c_gold; a_eat <= c_eat;
            a_adie <= c_adie; a_pdie <= c_pdie;
            for (int k = 0; k < 2; k++) begin
                e_died[k] <= 1'b0;
                e_resp[k] <= 1'b0;
                if (m_mode[k] == 0 && a_pdie) begin
                    e_died[k]  <= 1'b1;
                    m_lives[k] <= (m_lives[k] > 0) ? m_lives[k] - 1 : 0;
                    m_left[k]  <= df_of(k);
                    m_mode[k]  <= 1;
                end else if (m_mode[k] == 1) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        if (m_lives[k] == 0) begin
                            m_mode[k] <= 2;
                        end else begin
                            e_resp[k] <= 1'b1;
                            m_mode[k] <= 0;
                        end
                    end
                end
            end
        end else begin
            e_fire <= 1'b0; e_gold <= '0; e_eat <= '0; e_adie <= '0;
            a_fire <= a_fire | c_fire; a_gold <= a_gold | c_gold;
            a_eat  <= a_eat | c_eat;   a_adie <= a_adie | c_adie;
            a_pdie <= a_pdie | c_pdie;
            for (int k = 0; k < 2; k++) begin
                e_died[k] <= 1'b0;
                e_resp[k] <= 1'b0;
            end
        end
    end

    logic [20:0] want;
    logic        over;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            over = (m_mode[k] == 2);
            want = {e_fire & ~over, e_gold & {NG{~over}},
                    e_eat & {NG{~over}}, e_adie & {NA{~over}},
                    e_died[k], e_resp[k], over, 4'(m_lives[k]),
                    m_mode[k] == 0, terr & plr};
            total++;
            if (got[k] !== want) begin
                bad++;
                $display("FAIL cycle_cmp dut%0d t=%0t got=%h want=%h",
                         k, $time, got[k], want);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_pulse();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic clear_px();
        terr = 1'b0; plr = 1'b0; shot = 1'b0;
        adr  = '0;   gdr = '0;
    endtask

    initial begin
        reset = 1'b1; sof = 1'b0; awake = 1'b1; gst = '0;
        clear_px();
        tick(); tick();
        reset = 1'b0;
        chk("rst_lives0", d0_lives, 3);
        chk("rst_alive0", d0_alive, 1);
        chk("rst_go0", d0_go, 0);
        chk("rst_lives1", d1_lives, 1);
        sof_pulse();

        shot = 1'b1; adr = 3'b010;
        repeat (5) tick();
        clear_px();
        repeat (2) tick();
        sof_pulse();
        chk("shot_adie", d0_adie, 3'b010);
        chk("shot_fire", d0_fire, 1);
        tick();
        chk("shot_adie_off", d0_adie, 0);
        chk("shot_fire_off", d0_fire, 0);

        terr = 1'b1; plr = 1'b1;
        #1 chk("live_cpt", d0_cpt, 1);
        terr = 1'b0; gdr = 4'b0100; gst = 16'h0200;
        repeat (3) tick();
        clear_px();
        tick();
        sof_pulse();
        chk("eat_open", d0_eat, 4'b0100);
        chk("gold_open", d0_gold, 4'b0100);

        gst = 16'h0000; plr = 1'b1; gdr = 4'b0100;
        repeat (3) tick();
        clear_px();
        sof_pulse();
        chk("eat_idle", d0_eat, 0);
        chk("gold_idle", d0_gold, 4'b0100);

        awake = 1'b0; plr = 1'b1; adr = 3'b001;
        repeat (3) tick();
        clear_px(); awake = 1'b1;
        sof_pulse();
        chk("asleep_died", d0_died, 0);
        chk("asleep_lives", d0_lives, 3);

        sof = 1'b1; plr = 1'b1; adr = 3'b001;
        tick();
        sof = 1'b0; clear_px();
        chk("sofcyc_now", d0_died, 0);
        tick();
        sof_pulse();
        chk("sofcyc_died", d0_died, 1);
        chk("sofcyc_lives", d0_lives, 2);
        chk("sofcyc_alive", d0_alive, 0);
        chk("one_life_lives", d1_lives, 0);

        for (int f = 1; f <= 60; f++) begin
            plr = 1'b1; shot = 1'b1; adr = 3'b001;
            repeat (2) tick();
            clear_px();
            tick();
            sof_pulse();
            chk("no_redeath", d0_died, 0);
            if (f == 4) chk("one_life_over", d1_go, 1);
            if (f == 10) begin
                chk("dying_adie", d0_adie, 3'b001);
                chk("over_adie", d1_adie, 0);
                chk("over_fire", d1_fire, 0);
            end
            if (f == 59) chk("early_resp", d0_resp, 0);
            if (f == 60) begin
                chk("respawn", d0_resp, 1);
                chk("resp_alive", d0_alive, 1);
            end
        end
        tick();
        chk("respawn_off", d0_resp, 0);
        sof_pulse();
        chk("clean_died", d0_died, 0);

        gst = 16'h0010; gdr = 4'b0010; adr = 3'b001; plr = 1'b1;
        repeat (2) tick();
        clear_px(); gst = '0;
        sof_pulse();
        chk("fall_adie", d0_adie, 3'b001);
        chk("fall_died", d0_died, 1);
        chk("fall_lives", d0_lives, 1);
        chk("fall_gold", d0_gold, 4'b0010);

        shot = 1'b1; adr = 3'b100;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        clear_px();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        sof_pulse();
        chk("rst_mid_adie", d0_adie, 0);
        chk("rst_mid_lives0", d0_lives, 3);
        chk("rst_mid_lives1", d1_lives, 1);
        chk("rst_mid_alive1", d1_alive, 1);
        chk("rst_mid_go1", d1_go, 0);

        sof = 1'b1; shot = 1'b1; adr = 3'b100;
        tick();
        clear_px();
        chk("b2b_first", d0_adie, 0);
        tick();
        sof = 1'b0;
        chk("b2b_second", d0_adie, 3'b100);
        chk("b2b_fire", d0_fire, 1);
        tick();
        chk("b2b_off", d0_adie, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
